// File: rtl/rsa_montgomery_radix_if.sv
// Operand/result handshake bundle for the Montgomery multiplier.
// master = modular-exponentiation controller side, slave = multiplier side.
interface rsa_montgomery_radix_if #(
  parameter int MOD_WIDTH = 256
);
  logic                 i_valid;
  logic                 i_ready;
  logic [MOD_WIDTH-1:0] i_a;
  logic [MOD_WIDTH-1:0] i_b;
  logic [MOD_WIDTH-1:0] i_modulus;
  logic                 o_valid;
  logic                 o_ready;
  logic [MOD_WIDTH-1:0] o_out;

  modport master (
    output i_valid, i_a, i_b, i_modulus, o_ready,
    input  i_ready, o_valid, o_out
  );

  modport slave (
    input  i_valid, i_a, i_b, i_modulus, o_ready,
    output i_ready, o_valid, o_out
  );
endinterface

// File: rtl/rsa_montgomery_radix.sv
// Montgomery modular multiplier: out = a*b*2^(-MOD_WIDTH) mod N,
// BITS_PER_CYCLE radix-2 steps per clock, final subtraction in its own cycle.
//
// state | meaning
// IDLE  | ready for operands, operands latched on i_valid
// CALC  | BITS_PER_CYCLE chained radix-2 steps per clock
// SUB   | conditional subtraction r >= N -> r - N
// DONE  | result presented until o_ready
module rsa_montgomery_radix #(
  parameter int MOD_WIDTH      = 256,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst,
  rsa_montgomery_radix_if.slave bus
);
  localparam int STEPS = MOD_WIDTH / BITS_PER_CYCLE;
  localparam int W     = MOD_WIDTH + 2;
  localparam int CW    = $clog2(STEPS + 1);

  if (MOD_WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("rsa_montgomery_radix: BITS_PER_CYCLE must divide MOD_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, SUB, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic [W-1:0]         n_reg;
  logic [W-1:0]         r_reg;
  logic [W-1:0]         r_nxt;
  logic [W-1:0]         t;
  logic [W-1:0]         r_sub;
  logic [MOD_WIDTH-1:0] out_reg;
  logic                 last_step;

  assign last_step = (cnt == CW'(STEPS - 1));
  assign r_sub     = r_reg - n_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.i_valid) state_nxt = CALC;
      CALC: if (last_step)   state_nxt = SUB;
      SUB:                   state_nxt = DONE;
      DONE: if (bus.o_ready) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // a_reg is shifted right each CALC cycle, so bit j is multiplier bit cnt*K + j.
  // r < 2N keeps every intermediate below 4N, which fits in MOD_WIDTH+2 bits.
  always_comb begin
    r_nxt = r_reg;
    t     = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      t     = r_nxt + (a_reg[j] ? b_reg : '0);
      t     = t + (t[0] ? n_reg : '0);
      r_nxt = t >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      n_reg   <= '0;
      r_reg   <= '0;
      out_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            a_reg <= W'(bus.i_a);
            b_reg <= W'(bus.i_b);
            n_reg <= W'(bus.i_modulus);
            r_reg <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          r_reg <= r_nxt;
          a_reg <= a_reg >> BITS_PER_CYCLE;
          cnt   <= cnt + CW'(1);
        end
        SUB: out_reg <= (r_reg >= n_reg) ? r_sub[MOD_WIDTH-1:0] : r_reg[MOD_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign bus.i_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_out   = out_reg;
endmodule
